// File: rtl/bs_out_pack.sv
// Deflate output packer: reorders concatenator words into sink byte order, buffers them in a
// first-word-fall-through FIFO and closes the stream with a zero-padded final beat.
// Optional macro BS_OUT_BITREV_EN bit-reverses each byte (earliest stream bit at byte LSB).
module bs_out_pack #(
    parameter int FIFO_DEPTH = 8,
    parameter int AFULL_LVL  = FIFO_DEPTH - 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        val_i,
    input  logic [31:0] dat_i,
    input  logic        flush_i,
    input  logic [31:0] flush_dat_i,
    input  logic [4:0]  flush_numb_i,
    output logic        afull_o,
    output logic        err_o,
    output logic        val_o,
    output logic [31:0] dat_o,
    output logic [2:0]  byte_num_o,
    output logic        last_o,
    input  logic        rdy_i,
    output logic        done_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        ST_STREAM     = 2'd0,
        ST_FLUSH_PEND = 2'd1,
        ST_DRAIN      = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] dat;
        logic [2:0]  byte_num;
        logic        last;
    } entry_t;

    function automatic logic [7:0] order_byte(input logic [7:0] b);
        logic [7:0] r;
`ifdef BS_OUT_BITREV_EN
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
`else
        r = b;
`endif
        return r;
    endfunction

    // Stream byte k (counted from the MSB end) lands in output byte lane k.
    function automatic logic [31:0] order_word(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = order_byte(w[31-8*k -: 8]);
        end
        return r;
    endfunction

    function automatic entry_t data_entry(input logic [31:0] w);
        entry_t e;
        e.dat      = order_word(w);
        e.byte_num = 3'd4;
        e.last     = 1'b0;
        return e;
    endfunction

    // Residual bits are left-aligned so the earliest one becomes stream bit 0; the rest is zero pad.
    function automatic entry_t flush_entry(input logic [31:0] fd, input logic [4:0] n);
        entry_t      e;
        logic [5:0]  shamt;
        logic [5:0]  bits_up;
        logic [31:0] aligned;
        shamt      = 6'd32 - {1'b0, n};
        aligned    = (n == 5'd0) ? 32'd0 : (fd << shamt);
        bits_up    = {1'b0, n} + 6'd7;
        e.dat      = order_word(aligned);
        e.byte_num = bits_up[5:3];
        e.last     = 1'b1;
        return e;
    endfunction

    state_t          state_r;
    entry_t          pend_r;
    entry_t          mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   mem_cnt_r;

    state_t          nxt_state_s;
    logic            pop_s;
    logic            space_s;
    logic            push_req_s;
    logic            push_ok_s;
    logic            pend_load_s;
    logic            drop_err_s;
    logic            ovf_err_s;
    logic            load_s;
    logic            val_nxt_s;
    logic [CW-1:0]   occ_s;
    logic [CW-1:0]   mem_cnt_nxt_s;
    logic [CW-1:0]   occ_nxt_s;
    entry_t          push_ent_s;
    entry_t          head_s;

    // Push arbitration, FSM next state, and FIFO/output-stage bookkeeping.
    always_comb begin
        pop_s       = val_o && rdy_i;
        occ_s       = mem_cnt_r + {{AW{1'b0}}, val_o};
        space_s     = (occ_s < DEPTH_C) || pop_s;
        push_req_s  = 1'b0;
        push_ent_s  = '0;
        pend_load_s = 1'b0;
        drop_err_s  = 1'b0;
        nxt_state_s = state_r;
        case (state_r)
            ST_STREAM: begin
                if (val_i) begin
                    push_req_s = 1'b1;
                    push_ent_s = data_entry(dat_i);
                    if (flush_i) begin
                        pend_load_s = 1'b1;
                        nxt_state_s = ST_FLUSH_PEND;
                    end else begin
                        nxt_state_s = ST_STREAM;
                    end
                end else if (flush_i) begin
                    push_req_s = 1'b1;
                    push_ent_s = flush_entry(flush_dat_i, flush_numb_i);
                    if (space_s) begin
                        nxt_state_s = ST_DRAIN;
                    end else begin
                        nxt_state_s = ST_STREAM;
                    end
                end else begin
                    nxt_state_s = ST_STREAM;
                end
            end
            ST_FLUSH_PEND: begin
                // The latched flush beat simply waits for room; it is never lost.
                push_req_s = 1'b1;
                push_ent_s = pend_r;
                drop_err_s = val_i || flush_i;
                if (space_s) begin
                    nxt_state_s = ST_DRAIN;
                end else begin
                    nxt_state_s = ST_FLUSH_PEND;
                end
            end
            ST_DRAIN: begin
                drop_err_s = val_i || flush_i;
                if (pop_s && last_o) begin
                    nxt_state_s = ST_STREAM;
                end else begin
                    nxt_state_s = ST_DRAIN;
                end
            end
            default: begin
                nxt_state_s = ST_STREAM;
            end
        endcase
        push_ok_s     = push_req_s && space_s;
        ovf_err_s     = push_req_s && !space_s && (state_r != ST_FLUSH_PEND);
        load_s        = (mem_cnt_r != '0) && (!val_o || pop_s);
        mem_cnt_nxt_s = mem_cnt_r + {{AW{1'b0}}, push_ok_s} - {{AW{1'b0}}, load_s};
        if (load_s) begin
            val_nxt_s = 1'b1;
        end else if (pop_s) begin
            val_nxt_s = 1'b0;
        end else begin
            val_nxt_s = val_o;
        end
        occ_nxt_s = mem_cnt_nxt_s + {{AW{1'b0}}, val_nxt_s};
        head_s    = mem_r[rd_ptr_r];
    end

    // FIFO storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_ent_s;
        end
    end

    // Control state, pointers and the registered output stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_STREAM;
            pend_r     <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            mem_cnt_r  <= '0;
            val_o      <= 1'b0;
            dat_o      <= 32'd0;
            byte_num_o <= 3'd0;
            last_o     <= 1'b0;
            afull_o    <= 1'b0;
            err_o      <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state_r   <= nxt_state_s;
            mem_cnt_r <= mem_cnt_nxt_s;
            val_o     <= val_nxt_s;
            afull_o   <= (occ_nxt_s >= AFULL_C);
            err_o     <= err_o || drop_err_s || ovf_err_s;
            done_o    <= pop_s && last_o;
            if (pend_load_s) begin
                pend_r <= flush_entry(flush_dat_i, flush_numb_i);
            end
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (load_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                dat_o      <= head_s.dat;
                byte_num_o <= head_s.byte_num;
                last_o     <= head_s.last;
            end
        end
    end

endmodule

// File: doc/bs_out_pack.md
# bs_out_pack

Output packer for the deflate bitstream, directly downstream of the bit concatenator. It takes the 32-bit words the concatenator emits and reorders bits within each byte to deflate LSB-first order. It buffers the words in a small FIFO and hands them to the byte sink over a valid/ready handshake. It also closes the stream: the residual bits are zero-padded to a byte boundary and emitted as a final tagged beat.

## Interface
- FIFO_DEPTH, 8, FIFO entries; power of two, ≥4
- AFULL_LVL, FIFO_DEPTH-2, occupancy at which afull_o asserts
- clk  in  1  clock
- rstn  in  1  async active-low reset
- val_i  in  1  dat_i holds one full 32-bit stream word
- dat_i  in  32  stream word; bit 31 is the earliest stream bit
- flush_i  in  1  end of stream; residual bits on flush_dat_i/flush_numb_i
- flush_dat_i  in  32  residual bits, LSB-aligned; bit flush_numb_i-1 is the earliest
- flush_numb_i  in  5  residual bit count, 0..31
- afull_o  out  1  FIFO occupancy ≥ AFULL_LVL
- err_o  out  1  sticky: overflow, or input while draining
- val_o  out  1  output beat valid
- dat_o  out  32  output bytes; dat_o[7:0] is the first byte
- byte_num_o  out  3  valid bytes in beat, 0..4; low bytes are valid
- last_o  out  1  final beat of stream
- rdy_i  in  1  sink accepts beat when val_o && rdy_i
- done_o  out  1  one-cycle pulse after the last beat is accepted

## Operation
- Byte mapping: stream byte k = dat_i[31-8k -: 8]; it goes to dat_o[8k+7:8k], bit-reversed (see Configuration).
- Data word: pushed with byte_num=4, last=0.
- Flush word:
  - n = flush_numb_i; residual = flush_dat_i[n-1:0] left-aligned to bit 31, low bits zero.
  - byte_num = ceil(n/8), last = 1.
  - n=0 gives a beat with dat_o=0, byte_num_o=0, last_o=1.
- FIFO entry = {dat 32, byte_num 3, last 1}. Occupancy counter is 0..FIFO_DEPTH.
- FSM states:
  - STREAM (reset state):
    - val_i pushes the data word.
    - flush_i alone pushes the flush word → DRAIN.
    - val_i && flush_i pushes the data word and latches the flush fields → FLUSH_PEND.
  - FLUSH_PEND: pushes the latched flush word → DRAIN. A val_i here is dropped and sets err_o.
  - DRAIN: val_i or flush_i is dropped and sets err_o. When the last=1 beat is accepted → STREAM and pulse done_o.
- Overflow: a push while occupancy == FIFO_DEPTH with no pop in the same cycle is dropped and sets err_o.
- A push and a pop in the same cycle at full is legal; occupancy is unchanged.
- err_o clears only on reset.

## Timing
- Reset values: val_o=0, dat_o=0, byte_num_o=0, last_o=0, afull_o=0, err_o=0, done_o=0. FSM=STREAM, FIFO empty.
- Output is first-word-fall-through from a registered stage. A word pushed at edge t into an empty FIFO shows val_o=1 after edge t+1 (latency 1).
- Throughput is one beat per cycle with rdy_i held high.
- val_o, dat_o, byte_num_o and last_o hold stable while val_o && !rdy_i. val_o never drops without acceptance.
- afull_o is registered and reflects occupancy after the current edge.
- done_o asserts the cycle after the edge that accepts the last beat.
- Reset mid-stream discards FIFO contents and any pending flush. All outputs return to reset values asynchronously.

## Configuration
- BS_OUT_BITREV_EN:
  - Defined: each output byte is bit-reversed, so the earliest stream bit is at the byte LSB (deflate order).
  - Undefined: bytes pass unreversed, so the earliest bit is at the byte MSB. Byte order, flush and FSM are unchanged.

## Test plan
- Single word, macro defined: val_i, dat_i=0x80C00001, rdy_i=1 → one cycle later val_o=1, dat_o=0x80000301, byte_num_o=4, last_o=0.
- Partial flush: flush_i, flush_numb_i=5, flush_dat_i=0x00000013 → dat_o=0x00000019, byte_num_o=1, last_o=1; done_o pulses after acceptance.
- Concurrent flush: val_i&&flush_i, dat_i=0xFFFFFFFF, flush_numb_i=0 → beat 0xFFFFFFFF/4/last=0, then 0x00000000/0/last=1; a val_i in FLUSH_PEND sets err_o.
- Backpressure: push 8 words with rdy_i=0 → afull_o after the 6th push, no err_o; 9th push sets err_o. Release rdy_i → 8 beats in order, outputs held stable while stalled.
- Macro undefined: dat_i=0x80C00001 → dat_o=0x0100C080.
- Reset mid-drain: assert rstn=0 with 3 entries queued → val_o=0, err_o=0; the next stream starts cleanly in STREAM.
